bus_source_mux: RTL and testbench

//  Read side of the processor common bus: selects one register (AR..IR) or data memory as bus source,

---
 rtl/proc_pkg.sv | 25 ++
 rtl/bus_src_sel.sv | 48 ++++
 rtl/bus_source_mux.sv | 128 ++++++++++++
 tb/tb_bus_source_mux.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor bus definitions: widths and the 4-bit register code map used by
// both the bus read mux and the register write demux.
package proc_pkg;

   localparam int DATA_W = 16;
   localparam int SEL_W  = 4;

   localparam logic [SEL_W-1:0] SEL_AR   = 4'b0000;
   localparam logic [SEL_W-1:0] SEL_DR   = 4'b0001;
   localparam logic [SEL_W-1:0] SEL_R1   = 4'b0010;
   localparam logic [SEL_W-1:0] SEL_R2   = 4'b0011;
   localparam logic [SEL_W-1:0] SEL_R3   = 4'b0100;
   localparam logic [SEL_W-1:0] SEL_RA   = 4'b0101;
   localparam logic [SEL_W-1:0] SEL_RB   = 4'b0110;
   localparam logic [SEL_W-1:0] SEL_RC   = 4'b0111;
   localparam logic [SEL_W-1:0] SEL_AC   = 4'b1000;
   localparam logic [SEL_W-1:0] SEL_IR   = 4'b1010;
   localparam logic [SEL_W-1:0] SEL_DMEM = 4'b1011;

   // Codes 0000..1000 are contiguous registers; IR sits alone past the 1001 hole.
   function automatic logic is_reg_code(input logic [SEL_W-1:0] code);
      return (code <= SEL_AC) || (code == SEL_IR);
   endfunction

endpackage

// File: rtl/bus_src_sel.sv
// Combinational source decode: maps a bus source code to a register value and
// classifies the code as register, data memory, or invalid.
module bus_src_sel #(
   parameter int DATA_W = proc_pkg::DATA_W,
   parameter int SEL_W  = proc_pkg::SEL_W
) (
   input  logic [SEL_W-1:0]  sel,
   input  logic [DATA_W-1:0] ar_i,
   input  logic [DATA_W-1:0] dr_i,
   input  logic [DATA_W-1:0] r1_i,
   input  logic [DATA_W-1:0] r2_i,
   input  logic [DATA_W-1:0] r3_i,
   input  logic [DATA_W-1:0] ra_i,
   input  logic [DATA_W-1:0] rb_i,
   input  logic [DATA_W-1:0] rc_i,
   input  logic [DATA_W-1:0] ac_i,
   input  logic [DATA_W-1:0] ir_i,
   output logic [DATA_W-1:0] value,
   output logic              sel_is_reg,
   output logic              sel_is_mem,
   output logic              sel_bad
);
   import proc_pkg::*;

   always_comb begin
      value = '0;
      case (sel)
         SEL_AR:  value = ar_i;
         SEL_DR:  value = dr_i;
         SEL_R1:  value = r1_i;
         SEL_R2:  value = r2_i;
         SEL_R3:  value = r3_i;
         SEL_RA:  value = ra_i;
         SEL_RB:  value = rb_i;
         SEL_RC:  value = rc_i;
         SEL_AC:  value = ac_i;
         SEL_IR:  value = ir_i;
         default: value = '0;
      endcase
   end

   always_comb begin
      sel_is_reg = is_reg_code(sel);
      sel_is_mem = (sel == SEL_DMEM);
      sel_bad    = !(sel_is_reg || sel_is_mem);
   end

endmodule

// File: rtl/bus_source_mux.sv
// Read side of the common bus: one-cycle register reads, and data memory reads
// through a level req / ack handshake bounded by a wait-state timeout.
module bus_source_mux #(
   parameter int DATA_W      = proc_pkg::DATA_W,
   parameter int SEL_W       = proc_pkg::SEL_W,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [SEL_W-1:0]  rd_sel,
   input  logic [DATA_W-1:0] ar_i,
   input  logic [DATA_W-1:0] dr_i,
   input  logic [DATA_W-1:0] r1_i,
   input  logic [DATA_W-1:0] r2_i,
   input  logic [DATA_W-1:0] r3_i,
   input  logic [DATA_W-1:0] ra_i,
   input  logic [DATA_W-1:0] rb_i,
   input  logic [DATA_W-1:0] rc_i,
   input  logic [DATA_W-1:0] ac_i,
   input  logic [DATA_W-1:0] ir_i,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_rd_en,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_valid,
   output logic              busy,
   output logic              rd_err,
   output logic              fsm_state
);
   import proc_pkg::*;

   // Handshake: mem_rd_en is a level held from request until the edge that sees
   // mem_ack (or the timeout); mem_rdata is taken only on an edge with mem_ack=1.
   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

   localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [0:0]        state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [DATA_W-1:0] src_value;
   logic              sel_is_reg;
   logic              sel_is_mem;
   logic              sel_bad;

   bus_src_sel #(
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W)
   ) u_src_sel (
      .sel        (rd_sel),
      .ar_i       (ar_i),
      .dr_i       (dr_i),
      .r1_i       (r1_i),
      .r2_i       (r2_i),
      .r3_i       (r3_i),
      .ra_i       (ra_i),
      .rb_i       (rb_i),
      .rc_i       (rc_i),
      .ac_i       (ac_i),
      .ir_i       (ir_i),
      .value      (src_value),
      .sel_is_reg (sel_is_reg),
      .sel_is_mem (sel_is_mem),
      .sel_bad    (sel_bad)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         bus_out   <= '0;
         bus_valid <= 1'b0;
         rd_err    <= 1'b0;
         mem_rd_en <= 1'b0;
         busy      <= 1'b0;
      end else begin
         bus_valid <= 1'b0;
         rd_err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rd_req) begin
                  if (sel_is_reg) begin
                     bus_out   <= src_value;
                     bus_valid <= 1'b1;
                  end else if (sel_is_mem) begin
                     state     <= ST_MEM_WAIT;
                     wait_cnt  <= '0;
                     mem_rd_en <= 1'b1;
                     busy      <= 1'b1;
                  end else if (sel_bad) begin
                     rd_err <= 1'b1;
                  end
               end
            end
            ST_MEM_WAIT: begin
               // An ack arriving on the timeout edge still counts as a good read.
               if (mem_ack) begin
                  bus_out   <= mem_rdata;
                  bus_valid <= 1'b1;
                  mem_rd_en <= 1'b0;
                  busy      <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= ST_IDLE;
               end else if (wait_cnt == CNT_LAST) begin
                  rd_err    <= 1'b1;
                  mem_rd_en <= 1'b0;
                  busy      <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               state     <= ST_IDLE;
               mem_rd_en <= 1'b0;
               busy      <= 1'b0;
               wait_cnt  <= '0;
            end
         endcase
      end
   end

   assign fsm_state = state[0];

endmodule

// File: tb/tb_bus_source_mux.sv
// Bench for bus_source_mux: directed scenarios plus randomized transactions checked
// against a transaction-level model (register table lookup, ack-delay vs timeout).
module tb_bus_source_mux;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_req;
   logic [3:0]  rd_sel;
   logic [15:0] rv [16];
   logic [15:0] ar_i, dr_i, r1_i, r2_i, r3_i, ra_i, rb_i, rc_i, ac_i, ir_i;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        mem_rd_en;
   logic [15:0] bus_out;
   logic        bus_valid;
   logic        busy;
   logic        rd_err;
   logic        fsm_state;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_bus;
   logic [15:0] exp_q [$];

   // Register array indexed by bus source code.
   assign ar_i = rv[0];
   assign dr_i = rv[1];
   assign r1_i = rv[2];
   assign r2_i = rv[3];
   assign r3_i = rv[4];
   assign ra_i = rv[5];
   assign rb_i = rv[6];
   assign rc_i = rv[7];
   assign ac_i = rv[8];
   assign ir_i = rv[10];

   always #5 clk = ~clk;

   bus_source_mux #(.MEM_TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_req    (rd_req),
      .rd_sel    (rd_sel),
      .ar_i      (ar_i),
      .dr_i      (dr_i),
      .r1_i      (r1_i),
      .r2_i      (r2_i),
      .r3_i      (r3_i),
      .ra_i      (ra_i),
      .rb_i      (rb_i),
      .rc_i      (rc_i),
      .ac_i      (ac_i),
      .ir_i      (ir_i),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .mem_rd_en (mem_rd_en),
      .bus_out   (bus_out),
      .bus_valid (bus_valid),
      .busy      (busy),
      .rd_err    (rd_err),
      .fsm_state (fsm_state)
   );

   function automatic bit code_is_reg(input logic [3:0] c);
      return (c <= 4'd8) || (c == 4'd10);
   endfunction

   // Scoreboard: every bus_valid pulse must match the oldest expected value.
   always @(negedge clk) begin
      if (bus_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_valid: got bus_out=%h with no read outstanding", bus_out);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (bus_out !== e) begin
               bad++;
               $display("FAIL sb_bus_out: got %h want %h", bus_out, e);
            end
         end
      end
      if (bus_valid === 1'b1 && rd_err === 1'b1) begin
         total++;
         bad++;
         $display("FAIL valid_err_overlap: bus_valid=1 rd_err=1 same cycle");
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_regs();
      for (int i = 0; i < 16; i++) rv[i] = 16'($urandom);
   endtask

   task automatic do_reg(input logic [3:0] code, input string nm);
      rd_req  = 1'b1;
      rd_sel  = code;
      mem_ack = 1'($urandom_range(0, 1));
      exp_bus = rv[code];
      exp_q.push_back(rv[code]);
      step();
      total++;
      if (bus_out !== exp_bus || bus_valid !== 1'b1 || rd_err !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: got bus=%h v=%b e=%b busy=%b want bus=%h v=1 e=0 busy=0",
                  nm, bus_out, bus_valid, rd_err, busy, exp_bus);
      end
   endtask

   task automatic do_bad(input logic [3:0] code, input string nm);
      rd_req = 1'b1;
      rd_sel = code;
      step();
      rd_req = 1'b0;
      total++;
      if (rd_err !== 1'b1 || bus_valid !== 1'b0 || bus_out !== exp_bus) begin
         bad++;
         $display("FAIL %s: got e=%b v=%b bus=%h want e=1 v=0 bus=%h",
                  nm, rd_err, bus_valid, bus_out, exp_bus);
      end
      step();
      total++;
      if (rd_err !== 1'b0) begin
         bad++;
         $display("FAIL %s_pulse_width: rd_err=%b want 0", nm, rd_err);
      end
   endtask

   // d = wait cycles before ack; ack is asserted during enable cycle d+1.
   task automatic do_mem(input int d, input logic [15:0] data, input string nm);
      int hi;
      int exp_hi;
      bit ok;
      bit seen_v;
      bit seen_e;
      ok     = (d + 1 <= TMO);
      exp_hi = ok ? d + 1 : TMO;
      hi     = 0;
      seen_v = 0;
      seen_e = 0;
      rd_req = 1'b1;
      rd_sel = 4'hB;
      mem_ack = 1'b0;
      step();
      total++;
      if (mem_rd_en !== 1'b1 || busy !== 1'b1 || bus_valid !== 1'b0 || rd_err !== 1'b0) begin
         bad++;
         $display("FAIL %s_start: got en=%b busy=%b v=%b e=%b want en=1 busy=1 v=0 e=0",
                  nm, mem_rd_en, busy, bus_valid, rd_err);
      end
      if (ok) exp_q.push_back(data);
      for (int k = 1; k <= 40 && mem_rd_en === 1'b1; k++) begin
         hi++;
         rd_req    = 1'($urandom_range(0, 1));
         rd_sel    = 4'($urandom);
         mem_ack   = (k == d + 1);
         mem_rdata = (k == d + 1) ? data : 16'($urandom);
         step();
         if (bus_valid === 1'b1) seen_v = 1;
         if (rd_err === 1'b1) seen_e = 1;
         if (busy !== mem_rd_en) begin
            total++;
            bad++;
            $display("FAIL %s_busy_track: busy=%b mem_rd_en=%b", nm, busy, mem_rd_en);
         end
      end
      mem_ack = 1'b0;
      rd_req  = 1'b0;
      if (ok) exp_bus = data;
      total++;
      if (hi != exp_hi || seen_v != ok || seen_e != !ok || bus_out !== exp_bus || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: got en_cycles=%0d valid=%0d err=%0d bus=%h busy=%b want en_cycles=%0d valid=%0d err=%0d bus=%h busy=0",
                  nm, hi, seen_v, seen_e, bus_out, busy, exp_hi, ok, !ok, exp_bus);
      end
      step();
      total++;
      if (bus_valid !== 1'b0 || rd_err !== 1'b0 || bus_out !== exp_bus) begin
         bad++;
         $display("FAIL %s_after: got v=%b e=%b bus=%h want v=0 e=0 bus=%h",
                  nm, bus_valid, rd_err, bus_out, exp_bus);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         randomize_regs();
         rd_req    = 1'($urandom_range(0, 1));
         rd_sel    = 4'($urandom);
         mem_ack   = 1'($urandom_range(0, 1));
         mem_rdata = 16'($urandom);
         step();
      end
      total++;
      if (bus_out !== 16'h0 || bus_valid !== 1'b0 || busy !== 1'b0 || rd_err !== 1'b0 || mem_rd_en !== 1'b0) begin
         bad++;
         $display("FAIL reset: got bus=%h v=%b busy=%b e=%b en=%b want all 0",
                  bus_out, bus_valid, busy, rd_err, mem_rd_en);
      end
      rst     = 1'b0;
      rd_req  = 1'b0;
      mem_ack = 1'b0;
      exp_bus = 16'h0;
      step();
   endtask

   task automatic test_reg_read();
      rv[3] = 16'h1234;
      do_reg(4'b0011, "reg_r2");
      rd_req = 1'b0;
      step();
      total++;
      if (bus_valid !== 1'b0 || bus_out !== 16'h1234) begin
         bad++;
         $display("FAIL reg_r2_pulse: got v=%b bus=%h want v=0 bus=1234", bus_valid, bus_out);
      end
   endtask

   task automatic test_back_to_back();
      rv[0]  = 16'h0001;
      rv[8]  = 16'h0008;
      rv[10] = 16'h000A;
      do_reg(4'b0000, "b2b_ar");
      do_reg(4'b1000, "b2b_ac");
      do_reg(4'b1010, "b2b_ir");
      rd_req = 1'b0;
      step();
   endtask

   task automatic test_mem_ack();
      do_mem(3, 16'hBEEF, "mem_ack3");
   endtask

   task automatic test_mem_timeout();
      do_mem(TMO, 16'h5A5A, "mem_timeout");
      do_mem(TMO - 1, 16'hC0DE, "mem_ack_last");
      do_mem(0, 16'h7E57, "mem_ack0");
   endtask

   task automatic test_invalid();
      do_bad(4'b1001, "bad_1001");
      do_bad(4'b1111, "bad_1111");
      do_bad(4'b1100, "bad_1100");
   endtask

   task automatic test_reset_mid_wait();
      rd_req = 1'b1;
      rd_sel = 4'hB;
      step();
      rd_req = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      total++;
      if (mem_rd_en !== 1'b0 || busy !== 1'b0 || bus_valid !== 1'b0 || rd_err !== 1'b0 || bus_out !== 16'h0) begin
         bad++;
         $display("FAIL reset_mid_wait: got en=%b busy=%b v=%b e=%b bus=%h want all 0",
                  mem_rd_en, busy, bus_valid, rd_err, bus_out);
      end
      rst       = 1'b0;
      exp_bus   = 16'h0;
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      step();
      mem_ack = 1'b0;
      total++;
      if (bus_valid !== 1'b0 || rd_err !== 1'b0 || bus_out !== 16'h0 || mem_rd_en !== 1'b0) begin
         bad++;
         $display("FAIL idle_ack_ignored: got v=%b e=%b bus=%h en=%b want 0 0 0000 0",
                  bus_valid, rd_err, bus_out, mem_rd_en);
      end
   endtask

   task automatic test_random();
      logic [3:0] code;
      for (int t = 0; t < 60; t++) begin
         randomize_regs();
         code = 4'($urandom);
         if (code_is_reg(code)) do_reg(code, "rnd_reg");
         else if (code == 4'hB) do_mem($urandom_range(0, TMO + 2), 16'($urandom), "rnd_mem");
         else do_bad(code, "rnd_bad");
         if ($urandom_range(0, 2) == 0) begin
            rd_req = 1'b0;
            step();
         end
      end
      rd_req = 1'b0;
      step();
      step();
   endtask

   initial begin
      rst       = 1'b1;
      rd_req    = 1'b0;
      rd_sel    = 4'h0;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0;
      exp_bus   = 16'h0;
      randomize_regs();
      test_reset();
      test_reg_read();
      test_back_to_back();
      test_mem_ack();
      test_mem_timeout();
      test_invalid();
      test_reset_mid_wait();
      test_random();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: got %0d pending reads want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
